sram_responder: RTL
===================

Name: sram_responder

Overview:
- Synchronous single-port SRAM responder for the core's inst/data SRAM interface (en, wen, addr, wdata, rdata).
- Serves requests from an initiator such as the fetch stage, with a fixed 1-cycle read latency.
- Provides byte-enable writes, a base-address window check with a sticky error flag, and a backdoor init port used by the bench and the boot loader.
- Used as the instruction and data memory in simulation and in the FPGA top.

Parameters:
- ADDR_BASE, 32'h1c00_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of word count (4096 words = 16 KiB).
- INIT_ZERO, 1, 1: clear all words on reset; 0: contents untouched by reset.

Ports:
- clk  input  1  clock, all logic posedge.
- reset  input  1  synchronous, active-high.
- sram_en  input  1  request strobe; access performed this cycle.
- sram_wen  input  4  byte write enables; 4'h0 = read.
- sram_addr  input  32  byte address; bits [1:0] ignored.
- sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
- sram_rdata  output  32  read data, valid the cycle after an en=1 read.
- init_valid  input  1  backdoor word write.
- init_addr  input  DEPTH_LOG2  word index for backdoor write.
- init_data  input  32  backdoor write data (full word).
- init_busy  output  1  high while the reset clear sweep runs (INIT_ZERO=1).
- err  output  1  sticky out-of-window access flag.
- err_addr  output  32  address of the first out-of-window access.

Behaviour:
Address decode:
- word index = (sram_addr - ADDR_BASE) >> 2, 32-bit subtract with wrap.
- In window iff the difference < 2^(DEPTH_LOG2+2) (unsigned). Addresses below ADDR_BASE wrap to large values and are out of window.

Reset:
- sram_rdata=0, err=0, err_addr=0.
- If INIT_ZERO=1: init_busy=1 the cycle after reset deasserts. A sweep counter then writes 0 to one word per cycle, index 0 to 2^DEPTH_LOG2-1, and init_busy drops the cycle after the last word.
- Reset asserted mid-sweep restarts the sweep at index 0.
- While init_busy=1: sram_en requests are ignored (rdata holds, no write, no err) and init_valid is ignored.

Read (en=1, wen=0):
- sram_rdata = mem[index] at the next posedge; 1-cycle latency with no stall.
- Out of window: rdata=32'h0, error capture applies.

Write (en=1, wen!=0):
- Each byte lane with wen[i]=1 is updated; other lanes are preserved.
- The same cycle also performs a read with write-first policy: next-cycle rdata = merged new word.
- Out of window: no memory change, rdata=0, error capture applies.

Idle (en=0):
- sram_rdata holds its last value indefinitely.
- This hold is required because the initiator samples rdata after a back-pressured fetch.

Error capture:
- On the first out-of-window en=1 access after reset: err<=1, err_addr<=sram_addr.
- Later violations do not change either output until reset.

Backdoor:
- init_valid=1 writes the full word mem[init_addr]=init_data.
- If sram_en write and init_valid target the same word in the same cycle, the sram write wins for lanes with wen=1; the init data fills the remaining lanes.
- If the same-cycle sram read hits that word, rdata returns the merged result.
- init never affects rdata, err or err_addr otherwise.

Back-to-back:
- Write then read of the same address in consecutive cycles returns the new data; there is no hazard.

Test Plan:
- Reset then 2^DEPTH_LOG2+2 idle cycles with INIT_ZERO=1 -> init_busy high exactly 4096 cycles; read 0x1c00_0ffc returns 0; rdata=0 throughout.
- init_valid writes word 0 = 0x02c0_0000; en=1, addr=0x1c00_0000 -> rdata=0x02c0_0000 exactly one cycle later. Then en=0 for 5 cycles -> rdata holds 0x02c0_0000.
- Word 4 = 0x1122_3344; write wen=4'b0101, wdata=0xaabb_ccdd at 0x1c00_0010 -> next-cycle rdata=0x11bb_33dd; read next cycle -> 0x11bb_33dd.
- Read 0x1bff_fffc, then 0x1c00_4000 -> rdata=0 both times; err=1 and err_addr=0x1bff_fffc after the first, unchanged after the second; reset clears both.
- Same cycle: init_valid word 7 = 0xffff_ffff and sram write 0x1c00_001c, wen=4'b0011, wdata=0 -> mem[7]=0xffff_0000 and rdata=0xffff_0000.
- Assert reset at sweep index 100, release -> init_busy restarts and lasts 4096 cycles; en requests issued during the sweep are ignored.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: single-port SRAM model for the core inst/data SRAM bus.
// 1-cycle read latency, byte-enable writes with write-first readback,
// base-address window check with sticky error capture, a backdoor word
// write port and an optional zeroing sweep after reset.

// Per-byte-lane merge: write data wins where the lane enable is set.
module sram_lane_merge (
  input  logic [7:0] base,
  input  logic [7:0] wdata,
  input  logic       sel,
  output logic [7:0] merged
);
  assign merged = sel ? wdata : base;
endmodule

module sram_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sram_en,
  input  logic [3:0]            sram_wen,
  input  logic [31:0]           sram_addr,
  input  logic [31:0]           sram_wdata,
  output logic [31:0]           sram_rdata,
  input  logic                  init_valid,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_data,
  output logic                  init_busy,
  output logic                  err,
  output logic [31:0]           err_addr
);
  localparam int WORDS     = 1 << DEPTH_LOG2;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  logic [31:0] mem [WORDS];

  logic [31:0]                        offset;
  logic                               in_win;
  logic [DEPTH_LOG2-1:0]              idx;
  logic                               init_hit;
  logic [NUM_LANES-1:0][LANE_W-1:0]   base_word;
  logic [NUM_LANES-1:0][LANE_W-1:0]   wdata_word;
  logic [NUM_LANES-1:0][LANE_W-1:0]   merged_word;
  logic [DEPTH_LOG2-1:0]              sweep_idx;

  // Wrapping subtract: addresses below the base land far above the window.
  assign offset   = sram_addr - ADDR_BASE;
  assign in_win   = (offset >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign idx      = offset[DEPTH_LOG2+1:2];

  // A same-cycle backdoor write to the addressed word is visible to the
  // request: init data fills lanes the initiator does not write.
  assign init_hit   = init_valid && (init_addr == idx);
  assign base_word  = init_hit ? init_data : mem[idx];
  assign wdata_word = sram_wdata;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sram_lane_merge u_merge (
      .base   (base_word[l]),
      .wdata  (wdata_word[l]),
      .sel    (sram_wen[l]),
      .merged (merged_word[l])
    );
  end

  // Storage: zero sweep has priority; otherwise backdoor then initiator write.
  // The initiator write stores the merged word, so on a same-word collision
  // it already carries the init data in its unwritten lanes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_busy) begin
        mem[sweep_idx] <= '0;
      end else begin
        if (init_valid)
          mem[init_addr] <= init_data;
        if (sram_en && in_win && (sram_wen != 4'h0))
          mem[idx] <= merged_word;
      end
    end
  end

  // Control: sweep counter, read data register, sticky error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rdata <= '0;
      err        <= 1'b0;
      err_addr   <= '0;
      init_busy  <= INIT_ZERO;
      sweep_idx  <= '0;
    end else if (init_busy) begin
      sweep_idx <= sweep_idx + DEPTH_LOG2'(1);
      if (&sweep_idx)
        init_busy <= 1'b0;
    end else if (sram_en) begin
      sram_rdata <= in_win ? merged_word : 32'h0;
      if (!in_win && !err) begin
        err      <= 1'b1;
        err_addr <= sram_addr;
      end
    end
  end

endmodule
